multi_chan_xfer: RTL

Parametrised successor to the 16-channel sample-transfer block in the DAQ path. On each ready event it scans NCHAN channel FIFOs in ascending order, reads NSAMP samples from each enabled channel, and muxes them into a single DW-bit write stream toward the L1A ring buffer. It adds three things: a runtime channel mask, zero-padding on FIFO underrun so the frame length stays fixed, and an optional XOR checksum trailer. It sits between the per-channel sample FIFOs and the ring-buffer write port, and keeps the JTAG direct-read override.

---
 rtl/multi_chan_xfer_pkg.sv | 9 +
 rtl/multi_chan_xfer_chan_pick.sv | 24 ++
 rtl/multi_chan_xfer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/multi_chan_xfer_pkg.sv
// Shared state encoding and constants for the multi-channel sample transfer block.
package multi_chan_xfer_pkg;

  typedef enum logic [2:0] {IDLE, START, SEEK, READ, CKSUM, DRAIN} state_e;

  localparam int DRAIN_CYCLES = 2;
  localparam int PAD_WORD     = 0;

endpackage

// File: rtl/multi_chan_xfer_chan_pick.sv
// Lowest enabled channel at or above a start index; purely combinational.
module chan_pick #(
  parameter int NCHAN = 16,
  parameter int CHW   = $clog2(NCHAN)
) (
  input  logic [NCHAN-1:0] mask_i,
  input  logic [CHW-1:0]   start_i,
  output logic             found_o,
  output logic [CHW-1:0]   idx_o
);

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NCHAN-1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(start_i))) begin
        found_o = 1'b1;
        idx_o   = CHW'(i);
      end
    end
  end

endmodule

// File: rtl/multi_chan_xfer.sv
// Scans NCHAN channel FIFOs per event and muxes NSAMP samples per enabled channel into one write stream.
// Optional XOR trailer word built when MULTI_CHAN_XFER_CKSUM_EN is defined.
module multi_chan_xfer
  import multi_chan_xfer_pkg::*;
#(
  parameter int  NCHAN = 16,
  parameter int  DW    = 12,
  parameter int  NSAMP = 8,
  localparam int CHW   = $clog2(NCHAN)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                JTAG_MODE,
  input  logic                J_RD_FIFO,
  input  logic [NCHAN*DW-1:0] DIN,
  input  logic [NCHAN-1:0]    F_MT,
  input  logic                RDY,
  input  logic [NCHAN-1:0]    CHAN_MASK,
  output logic [NCHAN-1:0]    RD_ENA,
  output logic                L1A_RD_EN,
  output logic                WREN,
  output logic [DW-1:0]       DMUX,
  output logic [CHW-1:0]      CHAN_OUT,
  output logic                BUSY,
  output logic                DONE,
  output logic                UNDERRUN
);

  localparam int SW  = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
`ifdef MULTI_CHAN_XFER_CKSUM_EN
  localparam state_e END_ST = CKSUM;
`else
  localparam state_e END_ST = DRAIN;
`endif

  state_e           state_q, state_d;
  logic [NCHAN-1:0] mask_q, mask_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic             pick_found;
  logic [CHW-1:0]   pick_idx;
  logic             drain_last, slot_vld, slot_pad, re;

  logic [NCHAN-1:0] rd_ena_q;
  logic             vld1_q, pad1_q, wren_q, done_q, underrun_q;
  logic [CHW-1:0]   ch1_q, chan_q;
  logic [DW-1:0]    dmux_q, dmux_d;

  chan_pick #(.NCHAN(NCHAN), .CHW(CHW)) u_pick (
    .mask_i  (mask_q),
    .start_i (ch_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign drain_last = (dcnt_q == DCW'(DRAIN_CYCLES-1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      mask_q  <= '0;
      ch_q    <= '0;
      scnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      scnt_q  <= scnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    scnt_d  = scnt_q;
    dcnt_d  = (state_q == DRAIN) ? dcnt_q + 1'b1 : '0;
    case (state_q)
      IDLE:  if (RDY) state_d = START;
      START: begin
        mask_d  = CHAN_MASK;
        ch_d    = '0;
        scnt_d  = '0;
        state_d = SEEK;
      end
      SEEK: begin
        if (pick_found) begin
          ch_d    = pick_idx;
          state_d = READ;
        end else begin
          state_d = END_ST;
        end
      end
      READ: begin
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == SW'(NSAMP-1)) begin
          scnt_d = '0;
          if (ch_q == CHW'(NCHAN-1)) begin
            state_d = END_ST;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = SEEK;
          end
        end
      end
      CKSUM: state_d = DRAIN;
      DRAIN: if (drain_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // JTAG override wins over every transition, including leaving IDLE.
    if (JTAG_MODE) state_d = IDLE;
  end

  always_comb begin
    slot_vld = !JTAG_MODE && ((state_q == READ) || (state_q == CKSUM));
    slot_pad = (state_q == READ) && F_MT[ch_q];
    re       = !JTAG_MODE && (state_q == READ) && !F_MT[ch_q];
  end

  assign L1A_RD_EN = (state_q == START);
  assign BUSY      = (state_q != IDLE);

`ifdef MULTI_CHAN_XFER_CKSUM_EN
  logic          ck1_q;
  logic [DW-1:0] acc_q;

  // Accumulator folds in every data/pad word as it lands in DMUX.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ck1_q <= 1'b0;
      acc_q <= '0;
    end else begin
      ck1_q <= (state_q == CKSUM);
      if (state_q == START)      acc_q <= '0;
      else if (vld1_q && !ck1_q) acc_q <= acc_q ^ dmux_d;
    end
  end
`endif

  always_comb begin
    dmux_d = DIN[ch1_q*DW +: DW];
    if (pad1_q) dmux_d = DW'(PAD_WORD);
`ifdef MULTI_CHAN_XFER_CKSUM_EN
    if (ck1_q) dmux_d = acc_q;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ena_q   <= '0;
      vld1_q     <= 1'b0;
      pad1_q     <= 1'b0;
      ch1_q      <= '0;
      wren_q     <= 1'b0;
      dmux_q     <= '0;
      chan_q     <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rd_ena_q <= re ? (NCHAN'(1) << ch_q) : '0;
      vld1_q   <= slot_vld;
      pad1_q   <= slot_pad;
      ch1_q    <= ch_q;
      wren_q   <= vld1_q;
      if (vld1_q) begin
        dmux_q <= dmux_d;
        chan_q <= ch1_q;
      end
      done_q <= (state_q == DRAIN) && drain_last && !JTAG_MODE;
      if (state_q == START)          underrun_q <= 1'b0;
      else if (slot_vld && slot_pad) underrun_q <= 1'b1;
    end
  end

  assign RD_ENA   = JTAG_MODE ? {NCHAN{J_RD_FIFO}} : rd_ena_q;
  assign WREN     = wren_q;
  assign DMUX     = dmux_q;
  assign CHAN_OUT = chan_q;
  assign DONE     = done_q;
  assign UNDERRUN = underrun_q;

endmodule
